// File: rtl/exe_e2m_pkg.sv
// Shared CPU definitions: ALU op encodings, forward-select encodings, datapath width default.
package cpu_defs;

    localparam int DATA_W_DFLT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_LUI  = 4'b0101,
        ALU_SLL  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001,
        ALU_MUL  = 4'b1010,
        ALU_SRA  = 4'b1111
    } aluc_e;

    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_MALU = 2'b01,
        FWD_WDI  = 2'b10,
        FWD_ALT  = 2'b11
    } fwd_e;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

endpackage

// File: rtl/exe_e2m_alu32.sv
// Combinational ALU/shifter; shifts move B by A[4:0]. MUL is produced by the top, so it yields 0 here.
module alu32
    import cpu_defs::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        aluc,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [4:0] shamt;

    always_comb begin
        shamt  = a[4:0];
        result = '0;
        case (aluc_e'(aluc))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_LUI:  result = b << 16;
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_W-1){1'b0}}, (a < b)};
            default:  result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/exe_e2m.sv
// Execute stage + E/M register: forwarding muxes, ALU, zero flag.
// Define EXE_MUL_EN to add the iterative shift-add multiplier that stalls decode via estall.
module exe_e2m
    import cpu_defs::*;
#(
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              eshift,
    input  logic              ealuimm,
    input  logic              ewmem,
    input  logic              ewzero,
    input  logic [3:0]        ealuc,
    input  logic [4:0]        erd,
    input  logic [4:0]        esa,
    input  logic [DATA_W-1:0] eqa,
    input  logic [DATA_W-1:0] eqb,
    input  logic [DATA_W-1:0] eeximme,
    input  logic [1:0]        eadepend,
    input  logic [1:0]        ebdepend,
    input  logic [1:0]        esdepend,
    input  logic [DATA_W-1:0] wdi,
    output logic              mwreg,
    output logic              mm2reg,
    output logic              mwmem,
    output logic [4:0]        mrd,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mqb,
    output logic              zflag,
    output logic              estall
);

    logic [DATA_W-1:0] fa, fb, opa, opb, alu_res, res;
    logic [4:0]        fs;
    logic              alu_zero, res_zero, stall;

    always_comb begin
        case (fwd_e'(eadepend))
            FWD_MALU: fa = malu;
            FWD_WDI:  fa = wdi;
            default:  fa = eqa;
        endcase
        case (fwd_e'(ebdepend))
            FWD_MALU: fb = malu;
            FWD_WDI:  fb = wdi;
            default:  fb = eqb;
        endcase
        case (fwd_e'(esdepend))
            FWD_MALU: fs = malu[4:0];
            FWD_WDI:  fs = wdi[4:0];
            default:  fs = esa;
        endcase
        opa = eshift  ? {{(DATA_W-5){1'b0}}, fs} : fa;
        opb = ealuimm ? eeximme : fb;
    end

    alu32 #(.DATA_W(DATA_W)) u_alu (
        .a      (opa),
        .b      (opb),
        .aluc   (ealuc),
        .result (alu_res),
        .zero   (alu_zero)
    );

`ifdef EXE_MUL_EN
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] mcand, mplier, prod, step_prod;
    logic              last;

    // The final shift-add step is folded combinationally into the E/M load so
    // the product lands on the same edge that estall releases decode.
    always_comb begin
        step_prod = prod + (mplier[0] ? mcand : '0);
        last      = (state == MUL_BUSY) && (cnt == CNT_W'(MUL_CYCLES - 1));
        stall     = ((state == MUL_IDLE) && (aluc_e'(ealuc) == ALU_MUL)) ||
                    ((state == MUL_BUSY) && !last);
        res       = last ? step_prod : alu_res;
        res_zero  = last ? (step_prod == '0) : alu_zero;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state  <= MUL_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
        end else begin
            case (state)
                MUL_IDLE: begin
                    if (aluc_e'(ealuc) == ALU_MUL) begin
                        state  <= MUL_BUSY;
                        cnt    <= '0;
                        mcand  <= fa;
                        mplier <= opb;
                        prod   <= '0;
                    end
                end
                default: begin
                    prod   <= step_prod;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) state <= MUL_IDLE;
                end
            endcase
        end
    end
`else
    logic [31:0] unused_mul_cycles;

    assign unused_mul_cycles = MUL_CYCLES;
    assign stall             = 1'b0;
    assign res               = alu_res;
    assign res_zero          = alu_zero;
`endif

    assign estall = stall;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            mrd    <= '0;
            malu   <= '0;
            mqb    <= '0;
            zflag  <= 1'b0;
        end else if (stall) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            mrd    <= erd;
            malu   <= res;
            mqb    <= fb;
            if (ewzero) zflag <= res_zero;
        end
    end

endmodule

// File: tb/tb_exe_e2m.sv
// Directed vector bench for exe_e2m; the multiplier sequence is built when EXE_MUL_EN is defined.
module tb_exe_e2m;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        ewreg, em2reg, eshift, ealuimm, ewmem, ewzero;
    logic [3:0]  ealuc;
    logic [4:0]  erd, esa;
    logic [31:0] eqa, eqb, eeximme, wdi;
    logic [1:0]  eadepend, ebdepend, esdepend;
    logic        mwreg, mm2reg, mwmem, zflag, estall;
    logic [4:0]  mrd;
    logic [31:0] malu, mqb;

    int n_cmp = 0;
    int n_bad = 0;

    exe_e2m #(.DATA_W(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .clrn(clrn),
        .ewreg(ewreg), .em2reg(em2reg), .eshift(eshift), .ealuimm(ealuimm),
        .ewmem(ewmem), .ewzero(ewzero), .ealuc(ealuc), .erd(erd), .esa(esa),
        .eqa(eqa), .eqb(eqb), .eeximme(eeximme),
        .eadepend(eadepend), .ebdepend(ebdepend), .esdepend(esdepend), .wdi(wdi),
        .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem), .mrd(mrd),
        .malu(malu), .mqb(mqb), .zflag(zflag), .estall(estall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  aluc;
        logic [31:0] qa, qb, imm;
        logic [4:0]  sa;
        logic [1:0]  adep, bdep, sdep;
        logic        shift, aluimm, wreg, m2reg, wmem, wzero;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic [31:0] x_malu, x_mqb;
        logic        x_z;
    } vec_t;

    vec_t vt[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ealuc = v.aluc; eqa = v.qa; eqb = v.qb; eeximme = v.imm; esa = v.sa;
        eadepend = v.adep; ebdepend = v.bdep; esdepend = v.sdep;
        eshift = v.shift; ealuimm = v.aluimm; ewreg = v.wreg; em2reg = v.m2reg;
        ewmem = v.wmem; ewzero = v.wzero; erd = v.rd; wdi = v.wd;
    endtask

    task automatic nop();
        ealuc = 4'b0000; eqa = '0; eqb = '0; eeximme = '0; esa = '0;
        eadepend = 2'b00; ebdepend = 2'b00; esdepend = 2'b00;
        eshift = 0; ealuimm = 0; ewreg = 0; em2reg = 0; ewmem = 0; ewzero = 0;
        erd = '0; wdi = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".malu"},  malu,  32'h0);
        check({tag, ".mqb"},   mqb,   32'h0);
        check({tag, ".mrd"},   32'(mrd),   32'h0);
        check({tag, ".mwreg"}, 32'(mwreg), 32'h0);
        check({tag, ".mm2reg"},32'(mm2reg),32'h0);
        check({tag, ".mwmem"}, 32'(mwmem), 32'h0);
        check({tag, ".zflag"}, 32'(zflag), 32'h0);
        check({tag, ".estall"},32'(estall),32'h0);
    endtask

    initial begin
        //        aluc     qa           qb           imm        sa adep bdep sdep sh im wr m2 wm wz rd wd          x_malu       x_mqb        z
        vt[0]  = '{4'b0000, 32'd9,       32'd7,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 3, 32'h0,      32'h10,       32'd7,       0};
        vt[1]  = '{4'b0001, 32'hDEAD,    32'd1,       32'h0,     0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 4, 32'h0,      32'h0F,       32'd1,       0};
        vt[2]  = '{4'b0000, 32'd100,     32'd99,      32'h0,     0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 5, 32'd3,      32'd103,      32'd3,       0};
        vt[3]  = '{4'b1111, 32'h0,       32'h80000000,32'h0,     4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 6, 32'h0,      32'hF8000000, 32'h80000000,0};
        vt[4]  = '{4'b0111, 32'h0,       32'h80000000,32'h0,     9, 0, 0, 2, 1, 0, 1, 0, 0, 0, 7, 32'd1,      32'h40000000, 32'h80000000,0};
        vt[5]  = '{4'b0110, 32'h0,       32'h1234,    32'h0,     3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 8, 32'h0,      32'h91A0,     32'h1234,    0};
        vt[6]  = '{4'b0001, 32'd9,       32'd9,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9, 32'h0,      32'h0,        32'd9,       1};
        vt[7]  = '{4'b0000, 32'd2,       32'd3,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 10,32'h0,      32'd5,        32'd3,       1};
        vt[8]  = '{4'b0010, 32'hF0F01234,32'h0FF0FFFF,32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 11,32'h0,      32'h00F01234, 32'h0FF0FFFF,1};
        vt[9]  = '{4'b0011, 32'hF0000000,32'h0000000F,32'h0,     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 12,32'h0,      32'hF000000F, 32'hF,       1};
        vt[10] = '{4'b0100, 32'hFFFF0000,32'h0F0F0F0F,32'h0,     0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 13,32'h0,      32'hF0F00F0F, 32'h0F0F0F0F,1};
        vt[11] = '{4'b0101, 32'h0,       32'h55,      32'hABCD,  0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 14,32'h0,      32'hABCD0000, 32'h55,      1};
        vt[12] = '{4'b1000, 32'hFFFFFFFF,32'd1,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 15,32'h0,      32'd1,        32'd1,       0};
        vt[13] = '{4'b1001, 32'hFFFFFFFF,32'd1,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16,32'h0,      32'd0,        32'd1,       1};
        vt[14] = '{4'b0000, 32'hFFFFFFFF,32'd2,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 17,32'h0,      32'd1,        32'd2,       1};
        vt[15] = '{4'b0001, 32'd0,       32'd1,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 18,32'h0,      32'hFFFFFFFF, 32'd1,       1};
        vt[16] = '{4'b0000, 32'd1,       32'd7,       32'h10,    0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 19,32'h0,      32'h11,       32'hFFFFFFFF,0};
        vt[17] = '{4'b1011, 32'd3,       32'd4,       32'h0,     0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 20,32'h0,      32'h0,        32'd4,       1};
        vt[18] = '{4'b0000, 32'd4,       32'd4,       32'h0,     0, 3, 3, 0, 0, 0, 1, 0, 0, 0, 21,32'h0,      32'd8,        32'd4,       1};

        nop();
        clrn = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        clrn = 1'b1;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vt[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d.malu", i),   malu,         vt[i].x_malu);
            check($sformatf("v%0d.mqb", i),    mqb,          vt[i].x_mqb);
            check($sformatf("v%0d.mrd", i),    32'(mrd),     32'(vt[i].rd));
            check($sformatf("v%0d.mwreg", i),  32'(mwreg),   32'(vt[i].wreg));
            check($sformatf("v%0d.mm2reg", i), 32'(mm2reg),  32'(vt[i].m2reg));
            check($sformatf("v%0d.mwmem", i),  32'(mwmem),   32'(vt[i].wmem));
            check($sformatf("v%0d.zflag", i),  32'(zflag),   32'(vt[i].x_z));
            check($sformatf("v%0d.estall", i), 32'(estall),  32'h0);
        end

        // Asynchronous reset away from any clock edge
        @(negedge clk);
        #2;
        clrn = 1'b0;
        #1;
        check_all_zero("async_rst");
        nop();
        @(negedge clk);
        clrn = 1'b1;

`ifdef EXE_MUL_EN
        begin
            int n;
            @(negedge clk);
            nop();
            ealuc = 4'b1010; eqa = 32'd6; eqb = 32'd7; ewreg = 1; ewzero = 1; erd = 5'd5;
            #1;
            check("mul.estall_start", 32'(estall), 32'h1);
            n = 0;
            while (estall && n < 100) begin
                @(posedge clk);
                #1;
                check($sformatf("mul.bubble%0d", n), 32'(mwreg), 32'h0);
                n++;
            end
            check("mul.stall_cycles", 32'(n), 32'd32);
            @(posedge clk);
            #1;
            nop();
            #1;
            check("mul.malu",   malu,        32'd42);
            check("mul.mwreg",  32'(mwreg),  32'h1);
            check("mul.mrd",    32'(mrd),    32'd5);
            check("mul.zflag",  32'(zflag),  32'h0);
            check("mul.estall", 32'(estall), 32'h0);

            // Abort mid-BUSY
            @(negedge clk);
            ealuc = 4'b1010; eqa = 32'd3; eqb = 32'd3; ewreg = 1; erd = 5'd7;
            repeat (5) @(posedge clk);
            #1;
            check("abort.busy", 32'(estall), 32'h1);
            nop();
            clrn = 1'b0;
            #1;
            check_all_zero("abort");
            @(negedge clk);
            clrn = 1'b1;
            eqa = 32'd1; eqb = 32'd1; ewreg = 1; erd = 5'd2;
            #1;
            check("abort.idle", 32'(estall), 32'h0);
            @(posedge clk);
            #1;
            check("abort.next_malu", malu, 32'd2);
            check("abort.next_mrd", 32'(mrd), 32'd2);
        end
`else
        @(negedge clk);
        nop();
        ealuc = 4'b1010; eqa = 32'd6; eqb = 32'd7; ewreg = 1; erd = 5'd5;
        #1;
        check("nomul.estall_comb", 32'(estall), 32'h0);
        @(posedge clk);
        #1;
        check("nomul.malu",   malu,        32'h0);
        check("nomul.mwreg",  32'(mwreg),  32'h1);
        check("nomul.estall", 32'(estall), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
